wr_dest_pipe: RTL and testbench
===============================

# wr_dest_pipe

Producer side of the forwarding path. The block carries each instruction's destination register number and write enable from decode through the EX, MEM and WB stages. It drives the `alu_we`/`fw_alu_rn` and `mem_We`/`fw_mem_rn` pairs that the forwarding unit compares against source registers, and the register-file write port. It also detects load-use hazards that forwarding cannot cover, and inserts a one-cycle bubble for each.

## Interface
- `RN_W`, 5: register-number width.
- `STALL_CNT_W`, 16: width of the saturating load-stall counter.

- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `id_rd_i`  in  RN_W  destination register of the instruction in ID.
- `id_we_i`  in  1  the instruction in ID writes `id_rd_i`.
- `id_load_i`  in  1  the instruction in ID is a load (result available at the end of MEM).
- `id_rs_i`, `id_rt_i`  in  RN_W  source registers of the instruction in ID.
- `id_rs_use_i`, `id_rt_use_i`  in  1  the instruction in ID reads rs / rt.
- `pause_i`  in  1  global pipeline hold.
- `flush_i`  in  1  kill the instruction in ID.
- `alu_we`, `fw_alu_rn`  out  1 / RN_W  EX-stage write enable and register number.
- `mem_We`, `fw_mem_rn`  out  1 / RN_W  MEM-stage write enable and register number.
- `wb_we_o`, `wb_rn_o`  out  1 / RN_W  WB-stage register-file write.
- `ld_stall_o`  out  1  load-use stall request; freezes PC, IF and ID externally.
- `ld_stall_cnt_o`  out  STALL_CNT_W  count of load-stall cycles, saturating.

## Operation
- **Stages.** There are three stage registers: EX, MEM and WB. Each holds {we, rn}. EX additionally holds a load flag.
- **Capture gating.** An entry with rd == 0 is captured with we = 0. A downstream `we` is therefore never 1 with `rn` = 0.
- **Load-use hazard.** `ld_stall_o` = EX.load & EX.we & ((`id_rs_use_i` & `id_rs_i` == EX.rn) | (`id_rt_use_i` & `id_rt_i` == EX.rn)).
  - This is combinational from registered EX state and the ID inputs.
  - A load already in MEM needs no stall; the FW_MEM path covers it.
- **Advance rules.** They are evaluated at each posedge, in priority order:
  1. `rst`: all stages are set to {0,0}, the load flag to 0 and the counter to 0.
  2. `pause_i`: all stages hold and the counter holds.
  3. Otherwise WB ← MEM and MEM ← EX. EX is loaded as follows:
     - if `flush_i` or `ld_stall_o`, EX ← bubble {we = 0, rn = 0, load = 0};
     - otherwise EX ← {`id_we_i` & (`id_rd_i` != 0), `id_rd_i`, `id_load_i`}.
- **Stall counter.** `ld_stall_cnt_o` increments on each non-paused cycle with `ld_stall_o` = 1 and saturates at all-ones.
- **Back-to-back stalls.** A load-use stall lasts exactly one non-paused cycle. The bubble clears EX.load, so `ld_stall_o` drops on the next cycle.
- **Flush with stall.** `flush_i` together with `ld_stall_o` inserts one bubble. The flush takes effect and the ID-held instruction is discarded by the external logic.

## Timing
- **Reset values.** `alu_we`, `mem_We`, `wb_we_o` = 0. `fw_alu_rn`, `fw_mem_rn`, `wb_rn_o` = 0. `ld_stall_o` = 0. `ld_stall_cnt_o` = 0.
- **Latency.** The ID instruction appears on `alu_we`/`fw_alu_rn` 1 cycle after capture, on `mem_We`/`fw_mem_rn` after 2 cycles, and on `wb_*` after 3 cycles. Each additional cycle with `pause_i` high adds one cycle.
- **Output types.** All outputs except `ld_stall_o` are registered. `ld_stall_o` is valid in the same cycle as the ID inputs, with no combinational path from `pause_i` or `flush_i`.
- **Pause during stall.** While `pause_i` is held during a stall, `ld_stall_o` stays 1 and is not counted.
- **Reset mid-operation.** Reset in the middle of operation drops all in-flight entries within one cycle. No write enable survives reset.

## Structure
- **Shared package.** `RN_W` and the zero-register constant belong in `mips789_defs.v` beside the FW_* codes.
- **Sub-module.** One sub-module, `wr_stage_reg`. It is a parameterised {we, rn, extra} register with synchronous reset, hold and bubble inputs. It is instantiated three times; the WB and MEM stages leave the extra bit unused.
- **Stall logic.** The stall comparator and the counter live in the top module.

## Test plan
- **Plain pipeline flow.** After reset, push `id_rd_i`=5, `id_we_i`=1, no load. Expect `alu_we`=1, `fw_alu_rn`=5 at +1; `mem_We`/`fw_mem_rn`=5 at +2; `wb_we_o`/`wb_rn_o`=5 at +3. Every output is 0 during the reset cycle.
- **Zero-register suppression.** Push `id_rd_i`=0, `id_we_i`=1. Expect `alu_we`, `mem_We` and `wb_we_o` to stay 0 in every stage.
- **Load-use stall.** Push a load to r8. On the next cycle present `id_rs_i`=8 with `id_rs_use_i`=1.
  - Expect `ld_stall_o`=1 for one cycle, EX = bubble on the following cycle, and `ld_stall_cnt_o`=1.
  - With the instruction held, `ld_stall_o`=0 on the next cycle; MEM then shows r8.
- **Stall with load in MEM.** A load to r8 followed by one unrelated instruction, then a reader of r8. Expect `ld_stall_o`=0 throughout.
- **Pause and flush.** Hold `pause_i` for 3 cycles with r3 in EX: all outputs are frozen and the counter is unchanged. Then assert `flush_i` with `id_rd_i`=9, `id_we_i`=1: EX shows a bubble and r9 never appears on `alu_we`.
- **Counter saturation and reset.** With `STALL_CNT_W`=2, force 5 stall cycles; the counter reads 3. Assert `rst` for one cycle mid-stream; all outputs read 0 on the next cycle.

Source files
------------

// File: rtl/wr_dest_pipe_pkg.sv
// Shared definitions for the destination-register forwarding pipe.
// Register-number width, zero register and forwarding-select codes.
package wr_dest_pipe_pkg;

  localparam int DEF_RN_W        = 5;
  localparam int DEF_STALL_CNT_W = 16;
  localparam logic [DEF_RN_W-1:0] ZERO_RN = '0;

  typedef enum logic [1:0] {
    FW_NOP = 2'd0,
    FW_ALU = 2'd1,
    FW_MEM = 2'd2
  } fw_sel_e;

endpackage

// File: rtl/wr_dest_pipe_stage_reg.sv
// One {we, rn, extra} pipeline stage with sync reset, hold and bubble.
// Reset wins over hold; hold wins over bubble.
module wr_stage_reg #(
  parameter int RN_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_hold,
  input  logic            i_bubble,
  input  logic            i_we,
  input  logic [RN_W-1:0] i_rn,
  input  logic            i_extra,
  output logic            o_we,
  output logic [RN_W-1:0] o_rn,
  output logic            o_extra
);

  logic            r_we;
  logic [RN_W-1:0] r_rn;
  logic            r_extra;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_rn    <= '0;
      r_extra <= 1'b0;
    end else if (!i_hold) begin
      if (i_bubble) begin
        r_we    <= 1'b0;
        r_rn    <= '0;
        r_extra <= 1'b0;
      end else begin
        r_we    <= i_we;
        r_rn    <= i_rn;
        r_extra <= i_extra;
      end
    end
  end

  assign o_we    = r_we;
  assign o_rn    = r_rn;
  assign o_extra = r_extra;

endmodule

// File: rtl/wr_dest_pipe.sv
// Destination-register pipe EX/MEM/WB feeding the forwarding unit,
// with load-use hazard detection and a saturating stall counter.
module wr_dest_pipe
  import wr_dest_pipe_pkg::*;
#(
  parameter int RN_W        = DEF_RN_W,
  parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RN_W-1:0]        id_rd_i,
  input  logic                   id_we_i,
  input  logic                   id_load_i,
  input  logic [RN_W-1:0]        id_rs_i,
  input  logic [RN_W-1:0]        id_rt_i,
  input  logic                   id_rs_use_i,
  input  logic                   id_rt_use_i,
  input  logic                   pause_i,
  input  logic                   flush_i,
  output logic                   alu_we,
  output logic [RN_W-1:0]        fw_alu_rn,
  output logic                   mem_We,
  output logic [RN_W-1:0]        fw_mem_rn,
  output logic                   wb_we_o,
  output logic [RN_W-1:0]        wb_rn_o,
  output logic                   ld_stall_o,
  output logic [STALL_CNT_W-1:0] ld_stall_cnt_o
);

  logic                   w_ex_load;
  logic                   w_id_we;
  logic                   w_hit_rs;
  logic                   w_hit_rt;
  logic                   w_ld_stall;
  logic                   w_mem_unused;
  logic                   w_wb_unused;
  logic [STALL_CNT_W-1:0] r_cnt;

  // r0 is hardwired, so a write to it must never look forwardable
  assign w_id_we = id_we_i & (id_rd_i != '0);

  assign w_hit_rs   = id_rs_use_i & (id_rs_i == fw_alu_rn);
  assign w_hit_rt   = id_rt_use_i & (id_rt_i == fw_alu_rn);
  assign w_ld_stall = w_ex_load & alu_we & (w_hit_rs | w_hit_rt);
  assign ld_stall_o = w_ld_stall;

  wr_stage_reg #(.RN_W(RN_W)) u_ex (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (pause_i),
    .i_bubble (flush_i | w_ld_stall),
    .i_we     (w_id_we),
    .i_rn     (id_rd_i),
    .i_extra  (id_load_i),
    .o_we     (alu_we),
    .o_rn     (fw_alu_rn),
    .o_extra  (w_ex_load)
  );

  wr_stage_reg #(.RN_W(RN_W)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (pause_i),
    .i_bubble (1'b0),
    .i_we     (alu_we),
    .i_rn     (fw_alu_rn),
    .i_extra  (1'b0),
    .o_we     (mem_We),
    .o_rn     (fw_mem_rn),
    .o_extra  (w_mem_unused)
  );

  wr_stage_reg #(.RN_W(RN_W)) u_wb (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (pause_i),
    .i_bubble (1'b0),
    .i_we     (mem_We),
    .i_rn     (fw_mem_rn),
    .i_extra  (1'b0),
    .o_we     (wb_we_o),
    .o_rn     (wb_rn_o),
    .o_extra  (w_wb_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!pause_i && w_ld_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ld_stall_cnt_o = r_cnt;

endmodule

// File: tb/tb_wr_dest_pipe.sv
// Directed vector bench for wr_dest_pipe (stall counter width 2).
// Table rows plus hand sequences for saturation and mid-stream reset.
module tb_wr_dest_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rd_i, id_rs_i, id_rt_i;
  logic       id_we_i, id_load_i, id_rs_use_i, id_rt_use_i;
  logic       pause_i, flush_i;
  logic       alu_we, mem_We, wb_we_o, ld_stall_o;
  logic [4:0] fw_alu_rn, fw_mem_rn, wb_rn_o;
  logic [1:0] ld_stall_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wr_dest_pipe #(.RN_W(5), .STALL_CNT_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rd_i        (id_rd_i),
    .id_we_i        (id_we_i),
    .id_load_i      (id_load_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_rs_use_i    (id_rs_use_i),
    .id_rt_use_i    (id_rt_use_i),
    .pause_i        (pause_i),
    .flush_i        (flush_i),
    .alu_we         (alu_we),
    .fw_alu_rn      (fw_alu_rn),
    .mem_We         (mem_We),
    .fw_mem_rn      (fw_mem_rn),
    .wb_we_o        (wb_we_o),
    .wb_rn_o        (wb_rn_o),
    .ld_stall_o     (ld_stall_o),
    .ld_stall_cnt_o (ld_stall_cnt_o)
  );

  typedef struct {
    logic       rst, pause, flush;
    logic [4:0] rd;
    logic       we, ld;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic       stall;
    logic       aw;
    logic [4:0] arn;
    logic       mw;
    logic [4:0] mrn;
    logic       ww;
    logic [4:0] wrn;
    logic [1:0] cnt;
  } vec_t;

  function automatic vec_t mk(
    input int r, p, f, rd, we, ld, rs, rsu, rt, rtu,
    input int st, aw, arn, mw, mrn, ww, wrn, cnt);
    vec_t v;
    v.rst = 1'(r);   v.pause = 1'(p);  v.flush = 1'(f);
    v.rd = 5'(rd);   v.we = 1'(we);    v.ld = 1'(ld);
    v.rs = 5'(rs);   v.rsu = 1'(rsu);
    v.rt = 5'(rt);   v.rtu = 1'(rtu);
    v.stall = 1'(st);
    v.aw = 1'(aw);   v.arn = 5'(arn);
    v.mw = 1'(mw);   v.mrn = 5'(mrn);
    v.ww = 1'(ww);   v.wrn = 5'(wrn);
    v.cnt = 2'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int r, p, f, rd, we, ld,
                       input int rs, rsu, rt, rtu);
    rst = 1'(r); pause_i = 1'(p); flush_i = 1'(f);
    id_rd_i = 5'(rd); id_we_i = 1'(we); id_load_i = 1'(ld);
    id_rs_i = 5'(rs); id_rs_use_i = 1'(rsu);
    id_rt_i = 5'(rt); id_rt_use_i = 1'(rtu);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_we"}, int'(alu_we), 0);
    chk({tag, "_alu_rn"}, int'(fw_alu_rn), 0);
    chk({tag, "_mem_we"}, int'(mem_We), 0);
    chk({tag, "_mem_rn"}, int'(fw_mem_rn), 0);
    chk({tag, "_wb_we"}, int'(wb_we_o), 0);
    chk({tag, "_wb_rn"}, int'(wb_rn_o), 0);
    chk({tag, "_stall"}, int'(ld_stall_o), 0);
    chk({tag, "_cnt"}, int'(ld_stall_cnt_o), 0);
  endtask

  vec_t tv[23];

  initial begin
    // r p f rd we ld rs rsu rt rtu | st aw arn mw mrn ww wrn cnt
    tv[0]  = mk(1,0,0, 0,0,0, 0,0, 0,0,  0, 0,0,  0,0,  0,0,  0);
    tv[1]  = mk(0,0,0, 5,1,0, 0,0, 0,0,  0, 1,5,  0,0,  0,0,  0);
    tv[2]  = mk(0,0,0, 0,0,0, 0,0, 0,0,  0, 0,0,  1,5,  0,0,  0);
    tv[3]  = mk(0,0,0, 0,0,0, 0,0, 0,0,  0, 0,0,  0,0,  1,5,  0);
    tv[4]  = mk(0,0,0, 0,1,0, 0,0, 0,0,  0, 0,0,  0,0,  0,0,  0);
    tv[5]  = mk(0,0,0, 0,0,0, 0,0, 0,0,  0, 0,0,  0,0,  0,0,  0);
    tv[6]  = mk(0,0,0, 0,0,0, 0,0, 0,0,  0, 0,0,  0,0,  0,0,  0);
    tv[7]  = mk(0,0,0, 8,1,1, 0,0, 0,0,  0, 1,8,  0,0,  0,0,  0);
    tv[8]  = mk(0,0,0,10,1,0, 8,1, 0,0,  1, 0,0,  1,8,  0,0,  1);
    tv[9]  = mk(0,0,0,10,1,0, 8,1, 0,0,  0, 1,10, 0,0,  1,8,  1);
    tv[10] = mk(0,0,0, 8,1,1, 0,0, 0,0,  0, 1,8,  1,10, 0,0,  1);
    tv[11] = mk(0,0,0,11,1,0, 1,1, 0,0,  0, 1,11, 1,8,  1,10, 1);
    tv[12] = mk(0,0,0,12,1,0, 8,1, 8,1,  0, 1,12, 1,11, 1,8,  1);
    tv[13] = mk(0,0,0, 7,1,1, 0,0, 0,0,  0, 1,7,  1,12, 1,11, 1);
    tv[14] = mk(0,0,0, 0,0,0, 3,1, 7,1,  1, 0,0,  1,7,  1,12, 2);
    tv[15] = mk(0,0,0, 3,1,1, 0,0, 0,0,  0, 1,3,  0,0,  1,7,  2);
    tv[16] = mk(0,1,0, 4,1,0, 3,0, 3,0,  0, 1,3,  0,0,  1,7,  2);
    tv[17] = mk(0,1,0, 4,1,0, 3,1, 0,0,  1, 1,3,  0,0,  1,7,  2);
    tv[18] = mk(0,1,0, 4,1,0, 3,1, 0,0,  1, 1,3,  0,0,  1,7,  2);
    tv[19] = mk(0,0,1, 9,1,0, 3,1, 0,0,  1, 0,0,  1,3,  0,0,  3);
    tv[20] = mk(0,0,1, 9,1,0, 0,0, 0,0,  0, 0,0,  0,0,  1,3,  3);
    tv[21] = mk(0,0,0, 0,0,0, 0,0, 0,0,  0, 0,0,  0,0,  0,0,  3);
    tv[22] = mk(1,0,0, 5,1,0, 0,0, 0,0,  0, 0,0,  0,0,  0,0,  0);

    drive(1,0,0, 0,0,0, 0,0, 0,0);
    @(posedge clk);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].pause, tv[i].flush, tv[i].rd,
            tv[i].we, tv[i].ld, tv[i].rs, tv[i].rsu,
            tv[i].rt, tv[i].rtu);
      #1;
      if (!tv[i].rst)
        chk($sformatf("v%0d_stall", i), int'(ld_stall_o),
            int'(tv[i].stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_alu_we", i), int'(alu_we), int'(tv[i].aw));
      chk($sformatf("v%0d_alu_rn", i), int'(fw_alu_rn), int'(tv[i].arn));
      chk($sformatf("v%0d_mem_we", i), int'(mem_We), int'(tv[i].mw));
      chk($sformatf("v%0d_mem_rn", i), int'(fw_mem_rn), int'(tv[i].mrn));
      chk($sformatf("v%0d_wb_we", i), int'(wb_we_o), int'(tv[i].ww));
      chk($sformatf("v%0d_wb_rn", i), int'(wb_rn_o), int'(tv[i].wrn));
      chk($sformatf("v%0d_cnt", i), int'(ld_stall_cnt_o), int'(tv[i].cnt));
    end

    // five load-use stalls: counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(0,0,0, 8,1,1, 0,0, 0,0);
      #1;
      chk($sformatf("sat%0d_nostall", k), int'(ld_stall_o), 0);
      @(negedge clk);
      drive(0,0,0, 0,0,0, 8,1, 0,0);
      #1;
      chk($sformatf("sat%0d_stall", k), int'(ld_stall_o), 1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_cnt", k), int'(ld_stall_cnt_o),
          (k + 1 > 3) ? 3 : k + 1);
      chk($sformatf("sat%0d_bubble", k), int'(alu_we), 0);
    end

    // mid-stream reset with writes in flight
    @(negedge clk);
    drive(0,0,0, 6,1,0, 0,0, 0,0);
    @(negedge clk);
    drive(0,0,0, 7,1,1, 0,0, 0,0);
    @(posedge clk);
    #1;
    chk("pre_rst_alu_rn", int'(fw_alu_rn), 7);
    chk("pre_rst_mem_rn", int'(fw_mem_rn), 6);
    @(negedge clk);
    drive(1,0,0, 7,1,0, 7,1, 0,0);
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    drive(0,0,0, 0,0,0, 0,0, 0,0);
    @(posedge clk);
    #1;
    chk_all_zero("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
